// File: rtl/spell_exec_if.sv
// Instruction handshake and code/data memory port of the SPELL execution unit.
// The unit side is the master; fetch stage and memory arbiter sit on the slave side.
interface spell_exec_if #(
   parameter int WIDTH = 8
);
   // Handshakes: instr moves on an edge with instr_valid & instr_ready; a memory
   // access holds mem_req and its qualifiers stable until the edge that samples mem_ack.
   logic             instr_valid;
   logic             instr_ready;
   logic [7:0]       opcode;
   logic [WIDTH-1:0] pc;
   logic             mem_req;
   logic             mem_we;
   logic [1:0]       mem_type;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic [WIDTH-1:0] mem_rdata;
   logic             mem_ack;

   modport master (
      input  instr_valid, opcode, mem_rdata, mem_ack,
      output instr_ready, pc, mem_req, mem_we, mem_type, mem_addr, mem_wdata
   );
   modport slave (
      output instr_valid, opcode, mem_rdata, mem_ack,
      input  instr_ready, pc, mem_req, mem_we, mem_type, mem_addr, mem_wdata
   );
endinterface

// File: rtl/spell_exec_unit.sv
// SPELL stack-machine execution unit: register-file data stack, one opcode per
// handshake, memory access, delay and sleep states with sticky stack faults.
module spell_exec_unit #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int DELAY_UNIT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   spell_exec_if.master             bus,
   input  logic                     wake,
   output logic                     sleeping,
   output logic [1:0]               fault,
   output logic [$clog2(DEPTH):0]   depth,
   output logic [WIDTH-1:0]         tos,
   output logic [2:0]               dbg_state
);
   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;
   localparam int CW = WIDTH + 16;

   localparam logic [7:0] OP_ADD = "+", OP_SUB = "-", OP_AND = "&", OP_XOR = "^";
   localparam logic [7:0] OP_OR  = "|", OP_JMP = "=", OP_DLY = ",", OP_CST = "!";
   localparam logic [7:0] OP_DST = "w", OP_SHR = ">", OP_SHL = "<", OP_DUP = "2";
   localparam logic [7:0] OP_CLD = "?", OP_DLD = "r", OP_SLP = "z", OP_LOOP = "@";
   localparam logic [7:0] OP_SWP = "x";

   typedef enum logic [2:0] {
      S_READY = 3'd0, S_MEM = 3'd1, S_DELAY = 3'd2, S_SLEEP = 3'd3, S_FAULT = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] stk_q [DEPTH];
   logic [WIDTH-1:0] stk_d [DEPTH];
   logic [DW-1:0]    depth_q, depth_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [1:0]       fault_q, fault_d;
   logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [1:0]       mem_type_q, mem_type_d;
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sleeping_q, sleeping_d;

   logic [AW-1:0]    ti, bi, pi;
   logic [WIDTH-1:0] a, b;
   logic [DW-1:0]    need;
   logic             pushes;

   assign ti = AW'(depth_q - DW'(1));
   assign bi = AW'(depth_q - DW'(2));
   assign pi = depth_q[AW-1:0];
   assign b  = stk_q[ti];
   assign a  = stk_q[bi];

   always_comb begin
      need   = '0;
      pushes = 1'b0;
      case (bus.opcode)
         OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR, OP_CST, OP_DST, OP_LOOP, OP_SWP:
            need = DW'(2);
         OP_JMP, OP_DLY, OP_SHR, OP_SHL, OP_CLD, OP_DLD: need = DW'(1);
         OP_DUP: begin
            need   = DW'(1);
            pushes = 1'b1;
         end
         OP_SLP:  need = '0;
         default: pushes = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      stk_d       = stk_q;
      depth_d     = depth_q;
      pc_d        = pc_q;
      fault_d     = fault_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_type_d  = mem_type_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cnt_d       = cnt_q;
      sleeping_d  = sleeping_q;
      case (state_q)
         S_READY: if (bus.instr_valid && fault_q == 2'b00) begin
            if (depth_q < need) begin
               fault_d = 2'b10;
               state_d = S_FAULT;
            end else if (pushes && depth_q == DW'(DEPTH)) begin
               fault_d = 2'b01;
               state_d = S_FAULT;
            end else begin
               pc_d = pc_q + WIDTH'(1);
               case (bus.opcode)
                  OP_ADD: begin stk_d[bi] = a + b; depth_d = depth_q - DW'(1); end
                  OP_SUB: begin stk_d[bi] = a - b; depth_d = depth_q - DW'(1); end
                  OP_AND: begin stk_d[bi] = a & b; depth_d = depth_q - DW'(1); end
                  OP_XOR: begin stk_d[bi] = a ^ b; depth_d = depth_q - DW'(1); end
                  OP_OR:  begin stk_d[bi] = a | b; depth_d = depth_q - DW'(1); end
                  OP_SHR: stk_d[ti] = b >> 1;
                  OP_SHL: stk_d[ti] = b << 1;
                  OP_JMP: begin pc_d = b; depth_d = depth_q - DW'(1); end
                  OP_LOOP: begin
                     // Loop counter sits below the target; taken branches count it down.
                     if (a != '0) begin
                        pc_d      = b;
                        stk_d[bi] = a - WIDTH'(1);
                        depth_d   = depth_q - DW'(1);
                     end else begin
                        depth_d = depth_q - DW'(2);
                     end
                  end
                  OP_DUP: begin stk_d[pi] = b; depth_d = depth_q + DW'(1); end
                  OP_SWP: begin stk_d[ti] = a; stk_d[bi] = b; end
                  OP_CLD, OP_DLD: begin
                     mem_req_d  = 1'b1;
                     mem_we_d   = 1'b0;
                     mem_type_d = (bus.opcode == OP_CLD) ? 2'b10 : 2'b01;
                     mem_addr_d = b;
                     state_d    = S_MEM;
                  end
                  OP_CST, OP_DST: begin
                     mem_req_d   = 1'b1;
                     mem_we_d    = 1'b1;
                     mem_type_d  = (bus.opcode == OP_CST) ? 2'b10 : 2'b01;
                     mem_addr_d  = b;
                     mem_wdata_d = a;
                     depth_d     = depth_q - DW'(2);
                     state_d     = S_MEM;
                  end
                  OP_DLY: begin
                     depth_d = depth_q - DW'(1);
                     if (b != '0) begin
                        cnt_d   = CW'(b) * CW'(DELAY_UNIT);
                        state_d = S_DELAY;
                     end
                  end
                  OP_SLP: begin
                     sleeping_d = 1'b1;
                     state_d    = S_SLEEP;
                  end
                  default: begin stk_d[pi] = WIDTH'(bus.opcode); depth_d = depth_q + DW'(1); end
               endcase
            end
         end
         S_MEM: if (bus.mem_ack) begin
            if (!mem_we_q) stk_d[ti] = bus.mem_rdata;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_type_d  = 2'b00;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            state_d     = S_READY;
         end
         S_DELAY: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_READY;
         end
         S_SLEEP: if (wake) begin
            sleeping_d = 1'b0;
            state_d    = S_READY;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_READY;
         depth_q     <= '0;
         pc_q        <= '0;
         fault_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_type_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cnt_q       <= '0;
         sleeping_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         depth_q     <= depth_d;
         pc_q        <= pc_d;
         fault_q     <= fault_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_type_q  <= mem_type_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cnt_q       <= cnt_d;
         sleeping_q  <= sleeping_d;
      end
      stk_q <= stk_d;
   end

   assign bus.instr_ready = (state_q == S_READY) && (fault_q == 2'b00);
   assign bus.pc          = pc_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_type    = mem_type_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign sleeping        = sleeping_q;
   assign fault           = fault_q;
   assign depth           = depth_q;
   assign tos             = (depth_q == '0) ? '0 : b;
   assign dbg_state       = state_q;
endmodule

// File: tb/tb_spell_exec_unit.sv
// Directed bench for spell_exec_unit (WIDTH=8, DEPTH=4, DELAY_UNIT=4) with
// hand-computed expectations checked by immediate assertions.
module tb_spell_exec_unit;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wake = 1'b0;
   logic       sleeping;
   logic [1:0] fault;
   logic [2:0] depth;
   logic [7:0] tos;
   logic [2:0] dbg_state;
   int n_pass = 0;
   int n_total = 0;

   spell_exec_if #(.WIDTH(8)) bus ();

   spell_exec_unit #(.WIDTH(8), .DEPTH(4), .DELAY_UNIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .wake(wake), .sleeping(sleeping),
      .fault(fault), .depth(depth), .tos(tos), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic [7:0] op);
      int n = 0;
      while (!bus.instr_ready && n < 100) begin
         tick();
         n++;
      end
      if (n == 100) check("issue_timeout", 32'(bus.instr_ready), 32'd1);
      bus.opcode      = op;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
      bus.opcode      = 8'h00;
   endtask

   initial begin
      int lowc;
      bus.instr_valid = 1'b0;
      bus.opcode      = 8'h00;
      bus.mem_rdata   = 8'h00;
      bus.mem_ack     = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_pc", 32'(bus.pc), 0);
      check("rst_depth", 32'(depth), 0);
      check("rst_tos", 32'(tos), 0);
      check("rst_fault", 32'(fault), 0);
      check("rst_ready", 32'(bus.instr_ready), 1);
      check("rst_mem_req", 32'(bus.mem_req), 0);
      check("rst_sleeping", 32'(sleeping), 0);

      // "5" "3" "+" -> 0x35 + 0x33
      issue("5"); issue("3"); issue("+");
      check("add_tos", 32'(tos), 32'h68);
      check("add_depth", 32'(depth), 1);
      check("add_pc", 32'(bus.pc), 3);

      // Underflow: one entry, swap needs two
      do_reset();
      issue("1"); issue("x");
      check("uf_fault", 32'(fault), 2);
      check("uf_ready", 32'(bus.instr_ready), 0);
      check("uf_depth", 32'(depth), 1);
      check("uf_pc", 32'(bus.pc), 1);
      do_reset();
      check("uf_rst_fault", 32'(fault), 0);
      check("uf_rst_depth", 32'(depth), 0);
      check("uf_rst_ready", 32'(bus.instr_ready), 1);

      // Overflow on the fifth push into a 4-deep stack
      issue("A"); issue("B"); issue("C"); issue("D");
      check("pre_of_depth", 32'(depth), 4);
      issue("E");
      check("of_fault", 32'(fault), 1);
      check("of_depth", 32'(depth), 4);
      check("of_pc", 32'(bus.pc), 4);
      check("of_tos", 32'(tos), 32'h44);

      // ALU, shifts, dup, swap, loop and jump
      do_reset();
      issue(8'h09); issue(8'h05); issue("-");
      check("sub_tos", 32'(tos), 4);
      issue("2");
      check("dup_depth", 32'(depth), 2);
      check("dup_tos", 32'(tos), 4);
      issue("^");
      check("xor_tos", 32'(tos), 0);
      issue(8'h81); issue("<");
      check("shl_tos", 32'(tos), 32'h02);
      issue(">");
      check("shr_tos", 32'(tos), 32'h01);
      issue("x");
      check("swp_tos", 32'(tos), 0);
      check("swp_pc", 32'(bus.pc), 9);
      // stack [1, 0]: belowtop=1 -> branch to 0, counter becomes 0
      issue("@");
      check("loop_pc", 32'(bus.pc), 0);
      check("loop_depth", 32'(depth), 1);
      check("loop_tos", 32'(tos), 0);
      issue("7"); issue("=");
      check("jmp_pc", 32'(bus.pc), 32'h37);
      check("jmp_depth", 32'(depth), 1);
      // stack [0, 0x11]: belowtop=0 -> pop both, fall through
      issue(8'h11); issue("@");
      check("loop_nt_pc", 32'(bus.pc), 32'h39);
      check("loop_nt_depth", 32'(depth), 0);
      check("empty_tos", 32'(tos), 0);

      // Data read with mem_ack sampled on the third edge after acceptance
      do_reset();
      issue("A");
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 8'hAA;
      tick();
      bus.mem_ack = 1'b0;
      check("stray_ack_tos", 32'(tos), 32'h41);
      issue("r");
      check("rd_req", 32'(bus.mem_req), 1);
      check("rd_we", 32'(bus.mem_we), 0);
      check("rd_type", 32'(bus.mem_type), 1);
      check("rd_addr", 32'(bus.mem_addr), 32'h41);
      check("rd_pc", 32'(bus.pc), 2);
      tick();
      check("rd_hold_addr1", 32'(bus.mem_addr), 32'h41);
      check("rd_hold_req1", 32'(bus.mem_req), 1);
      tick();
      check("rd_hold_addr2", 32'(bus.mem_addr), 32'h41);
      check("rd_hold_type2", 32'(bus.mem_type), 1);
      check("rd_busy", 32'(bus.instr_ready), 0);
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 8'h7E;
      tick();
      bus.mem_ack = 1'b0;
      check("rd_tos", 32'(tos), 32'h7E);
      check("rd_ready", 32'(bus.instr_ready), 1);
      check("rd_req_done", 32'(bus.mem_req), 0);
      check("rd_depth", 32'(depth), 1);

      // Code write: addr = top (0x10), data = belowtop (0x7E)
      issue(8'h10); issue("!");
      check("wr_req", 32'(bus.mem_req), 1);
      check("wr_we", 32'(bus.mem_we), 1);
      check("wr_type", 32'(bus.mem_type), 2);
      check("wr_addr", 32'(bus.mem_addr), 32'h10);
      check("wr_data", 32'(bus.mem_wdata), 32'h7E);
      check("wr_depth", 32'(depth), 0);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("wr_ready", 32'(bus.instr_ready), 1);
      check("wr_req_done", 32'(bus.mem_req), 0);

      // Delay of 2 units at 4 cycles per unit
      do_reset();
      issue(8'h02); issue(",");
      lowc = 0;
      while (!bus.instr_ready && lowc < 50) begin
         lowc++;
         tick();
      end
      check("dly_cycles", 32'(lowc), 8);
      check("dly_pc", 32'(bus.pc), 2);
      check("dly_depth", 32'(depth), 0);
      issue(8'h00); issue(",");
      check("dly0_ready", 32'(bus.instr_ready), 1);
      check("dly0_depth", 32'(depth), 0);

      // Sleep / wake
      issue("z");
      check("slp_sleeping", 32'(sleeping), 1);
      check("slp_ready", 32'(bus.instr_ready), 0);
      check("slp_pc", 32'(bus.pc), 5);
      for (int i = 0; i < 10; i++) tick();
      check("slp_still", 32'(sleeping), 1);
      wake = 1'b1;
      tick();
      wake = 1'b0;
      check("wake_sleeping", 32'(sleeping), 0);
      check("wake_ready", 32'(bus.instr_ready), 1);

      // Reset while a request is pending
      issue(8'h20); issue("r");
      check("rstmem_req", 32'(bus.mem_req), 1);
      do_reset();
      check("rstmem_req_drop", 32'(bus.mem_req), 0);
      check("rstmem_type", 32'(bus.mem_type), 0);
      check("rstmem_addr", 32'(bus.mem_addr), 0);
      check("rstmem_ready", 32'(bus.instr_ready), 1);
      check("rstmem_pc", 32'(bus.pc), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
